// File: rtl/sound_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : sound_pkg
// Brief  : Melody codes, note pitches and lookup helpers for sound_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package sound_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        COIN = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } melody_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int HP_W    = 17;
    localparam int FRAME_W = 8;

    localparam logic [3:0] CODE_COIN = 4'd14;
    localparam logic [3:0] CODE_WIN  = 4'd1;
    localparam logic [3:0] CODE_LOSE = 4'd2;

    // Half-periods in 50 MHz clock cycles
    localparam logic [HP_W-1:0] HP_A4 = 17'd56818;
    localparam logic [HP_W-1:0] HP_C5 = 17'd47801;
    localparam logic [HP_W-1:0] HP_E5 = 17'd37936;
    localparam logic [HP_W-1:0] HP_G5 = 17'd31888;
    localparam logic [HP_W-1:0] HP_C6 = 17'd23878;

    localparam logic [2:0] LEN_COIN = 3'd2;
    localparam logic [2:0] LEN_WIN  = 3'd4;
    localparam logic [2:0] LEN_LOSE = 3'd4;

    function automatic melody_e decode_code(input logic [3:0] code);
        case (code)
            CODE_COIN: decode_code = COIN;
            CODE_WIN:  decode_code = WIN;
            CODE_LOSE: decode_code = LOSE;
            default:   decode_code = NONE;
        endcase
    endfunction

    function automatic logic [2:0] melody_len(input melody_e m);
        case (m)
            COIN:    melody_len = LEN_COIN;
            WIN:     melody_len = LEN_WIN;
            LOSE:    melody_len = LEN_LOSE;
            default: melody_len = 3'd0;
        endcase
    endfunction

    function automatic logic [HP_W-1:0] note_half_period(input melody_e m, input logic [2:0] idx);
        note_half_period = '0;
        case (m)
            COIN: begin
                case (idx)
                    3'd0:    note_half_period = HP_E5;
                    3'd1:    note_half_period = HP_C6;
                    default: note_half_period = '0;
                endcase
            end
            WIN: begin
                case (idx)
                    3'd0:    note_half_period = HP_C5;
                    3'd1:    note_half_period = HP_E5;
                    3'd2:    note_half_period = HP_G5;
                    3'd3:    note_half_period = HP_C6;
                    default: note_half_period = '0;
                endcase
            end
            LOSE: begin
                case (idx)
                    3'd0:    note_half_period = HP_G5;
                    3'd1:    note_half_period = HP_E5;
                    3'd2:    note_half_period = HP_C5;
                    3'd3:    note_half_period = HP_A4;
                    default: note_half_period = '0;
                endcase
            end
            default: note_half_period = '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tone_gen
// Brief  : Half-period counter and toggle flop producing a gated square wave.
// Rev    : 1.0  initial release
// ============================================================================
module tone_gen
    import sound_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            enable,
    input  logic            mute,
    input  logic [HP_W-1:0] half_period,
    output logic            square
);

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic            square_q, square_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear || !enable) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == half_period - 17'd1) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 17'd1;
        end
        // Mute only masks the output; the phase keeps running underneath
        square_d = phase_d & ~mute;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            square_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            square_q <= square_d;
        end
    end

    assign square = square_q;

endmodule
`default_nettype wire

// File: rtl/sound_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : sound_sequencer
// Brief  : Plays coin/win/lose melodies on a square-wave speaker output.
// Rev    : 1.0  initial release
// ============================================================================
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int NOTE_FRAMES = 6,
    parameter int GAP_FRAMES  = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [3:0]  sound_code,
    input  logic        mute,
    output logic        audio_out,
    output logic        busy,
    output logic [1:0]  melody_id,
    output logic [2:0]  note_idx,
    output logic [16:0] half_period
);

    localparam logic [FRAME_W-1:0] NOTE_FRAMES_C = FRAME_W'(NOTE_FRAMES);
    localparam logic [FRAME_W-1:0] GAP_FRAMES_C  = FRAME_W'(GAP_FRAMES);

    state_e             state_q, state_d;
    melody_e            melody_q, melody_d;
    logic [2:0]         note_q, note_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [HP_W-1:0]    hp_q, hp_d;
    logic [3:0]         last_code_q;

    melody_e mel_now, mel_last;
    logic    trigger, accept, tone_restart, tone_enable;

    always_comb begin
        mel_now  = decode_code(sound_code);
        mel_last = decode_code(last_code_q);
        trigger  = (mel_now != NONE) && (mel_now != mel_last);
        // Equal priority is accepted so a repeated event restarts its melody
        accept   = trigger && (2'(mel_now) >= 2'(melody_q));
    end

    always_comb begin
        state_d      = state_q;
        melody_d     = melody_q;
        note_d       = note_q;
        frame_d      = frame_q;
        hp_d         = hp_q;
        tone_restart = 1'b0;

        if (accept) begin
            state_d      = TONE;
            melody_d     = mel_now;
            note_d       = 3'd0;
            frame_d      = NOTE_FRAMES_C;
            hp_d         = note_half_period(mel_now, 3'd0);
            tone_restart = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                end
                TONE: begin
                    if (startOfFrame) begin
                        if (frame_q > 1) begin
                            frame_d = frame_q - 1'b1;
                        end else if (note_q == melody_len(melody_q) - 3'd1) begin
                            state_d  = IDLE;
                            melody_d = NONE;
                            note_d   = 3'd0;
                            frame_d  = '0;
                            hp_d     = '0;
                        end else if (GAP_FRAMES == 0) begin
                            state_d      = TONE;
                            note_d       = note_q + 3'd1;
                            frame_d      = NOTE_FRAMES_C;
                            hp_d         = note_half_period(melody_q, note_q + 3'd1);
                            tone_restart = 1'b1;
                        end else begin
                            state_d = GAP;
                            frame_d = GAP_FRAMES_C;
                        end
                    end
                end
                GAP: begin
                    if (startOfFrame) begin
                        if (frame_q > 1) begin
                            frame_d = frame_q - 1'b1;
                        end else begin
                            state_d      = TONE;
                            note_d       = note_q + 3'd1;
                            frame_d      = NOTE_FRAMES_C;
                            hp_d         = note_half_period(melody_q, note_q + 3'd1);
                            tone_restart = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    melody_d = NONE;
                    note_d   = 3'd0;
                    frame_d  = '0;
                    hp_d     = '0;
                end
            endcase
        end

        // Looking at the next state lets the output drop on the same edge
        tone_enable = (state_d == TONE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            melody_q    <= NONE;
            note_q      <= 3'd0;
            frame_q     <= '0;
            hp_q        <= '0;
            last_code_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            melody_q    <= melody_d;
            note_q      <= note_d;
            frame_q     <= frame_d;
            hp_q        <= hp_d;
            last_code_q <= sound_code;
        end
    end

    tone_gen u_tone_gen (
        .clk         (clk),
        .rst_n       (resetN),
        .clear       (tone_restart),
        .enable      (tone_enable),
        .mute        (mute),
        .half_period (hp_q),
        .square      (audio_out)
    );

    assign busy        = (state_q != IDLE);
    assign melody_id   = melody_q;
    assign note_idx    = note_q;
    assign half_period = hp_q;

endmodule
`default_nettype wire
